// File: rtl/fetch_pkg.sv
// Shared fetch-stage widths, bubble encoding and the fetch bundle handed to decode.
package fetch_pkg;

    localparam int unsigned PC_W = 10;
    localparam int unsigned IR_W = 16;

    localparam logic [IR_W-1:0] NOP_IR = 16'h0000;

    typedef struct packed {
        logic            valid;
        logic [IR_W-1:0] ir;
        logic [PC_W-1:0] pc;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer: catches the in-flight fetch when decode stalls.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_load,
    input  logic          i_drain,
    input  fetch_bundle_t i_bundle,
    output fetch_bundle_t o_bundle
);

    fetch_bundle_t r_entry;

    // Reset and flush dominate; load and drain are never requested together.
    always_ff @(posedge clk) begin
        if (i_reset || i_flush) begin
            r_entry <= '{valid: 1'b0, ir: NOP_IR, pc: '0};
        end else if (i_load) begin
            r_entry <= i_bundle;
        end else if (i_drain) begin
            r_entry.valid <= 1'b0;
        end
    end

    assign o_bundle = r_entry;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem and feeds
// decode through a registered valid/stall interface backed by a skid entry.
module fetch_unit #(
    parameter int unsigned     PC_W     = fetch_pkg::PC_W,
    parameter int unsigned     IR_W     = fetch_pkg::IR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IR_W-1:0] imem_q,
    output logic            fd_valid,
    output logic [IR_W-1:0] fd_ir,
    output logic [PC_W-1:0] fd_pc
);

    localparam int unsigned B_PC_W = fetch_pkg::PC_W;
    localparam int unsigned B_IR_W = fetch_pkg::IR_W;

    logic [PC_W-1:0] r_pc;
    logic            r_inflight_valid;
    logic [PC_W-1:0] r_inflight_pc;
    logic            r_fd_valid;
    logic [IR_W-1:0] r_fd_ir;
    logic [PC_W-1:0] r_fd_pc;

    fetch_pkg::fetch_bundle_t w_skid_in;
    fetch_pkg::fetch_bundle_t w_skid_out;
    logic                     w_skid_load;
    logic                     w_skid_drain;

    // The memory returns the in-flight word this cycle; park it if decode stalls.
    assign w_skid_in    = '{valid: 1'b1,
                            ir:    B_IR_W'(imem_q),
                            pc:    B_PC_W'(r_inflight_pc)};
    assign w_skid_load  = !reset && !redirect && stall && r_inflight_valid;
    assign w_skid_drain = !stall && w_skid_out.valid;

    fetch_skid u_skid (
        .clk      (clk),
        .i_reset  (reset),
        .i_flush  (redirect),
        .i_load   (w_skid_load),
        .i_drain  (w_skid_drain),
        .i_bundle (w_skid_in),
        .o_bundle (w_skid_out)
    );

    // PC and in-flight tracking: issue every unstalled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
        end else if (redirect) begin
            r_pc             <= redirect_pc;
            r_inflight_valid <= 1'b0;
        end else if (!stall) begin
            r_pc             <= r_pc + PC_W'(1);
            r_inflight_valid <= 1'b1;
            r_inflight_pc    <= r_pc;
        end else begin
            r_inflight_valid <= 1'b0;
        end
    end

    // Decode-facing register: skid entry has priority over the fresh fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fd_valid <= 1'b0;
            r_fd_ir    <= '0;
            r_fd_pc    <= '0;
        end else if (redirect) begin
            r_fd_valid <= 1'b0;
            r_fd_ir    <= IR_W'(fetch_pkg::NOP_IR);
        end else if (!stall) begin
            if (w_skid_out.valid) begin
                r_fd_valid <= 1'b1;
                r_fd_ir    <= IR_W'(w_skid_out.ir);
                r_fd_pc    <= PC_W'(w_skid_out.pc);
            end else if (r_inflight_valid) begin
                r_fd_valid <= 1'b1;
                r_fd_ir    <= imem_q;
                r_fd_pc    <= r_inflight_pc;
            end else begin
                r_fd_valid <= 1'b0;
                r_fd_ir    <= IR_W'(fetch_pkg::NOP_IR);
            end
        end
    end

    assign imem_addr = r_pc;
    assign fd_valid  = r_fd_valid;
    assign fd_ir     = r_fd_ir;
    assign fd_pc     = r_fd_pc;

endmodule
